// File: rtl/tile_feeder.sv
// tile_feeder: DEPTH-row FIFO feeding one tile, 1-cycle latency; io_in_ready low when full, io_stall freezes output stage.
// Define TILE_FEEDER_ZERO_FILL_EN to drive a/b/d to zero while io_out_valid_0 is low (default: hold last row).
module tile_feeder #(
   parameter int DBITS = 20,
   parameter int DEPTH = 4
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     io_in_valid,
   output logic                     io_in_ready,
   input  logic [7:0]               io_in_a,
   input  logic [18:0]              io_in_b,
   input  logic [DBITS-1:0]         io_in_d,
   input  logic [5:0]               io_in_shift,
   input  logic                     io_in_last,
   input  logic                     io_stall,
   output logic [7:0]               io_out_a_0,
   output logic [18:0]              io_out_b_0,
   output logic [DBITS-1:0]         io_out_d_0,
   output logic                     io_out_control_0_propagate,
   output logic [5:0]               io_out_control_0_shift,
   output logic                     io_out_valid_0,
   output logic [$clog2(DEPTH):0]   io_count
);
   localparam int AW = $clog2(DEPTH);
   localparam int RW = 8 + 19 + DBITS + 6 + 1;
   localparam logic [AW:0]   L_DEPTH = (AW+1)'(DEPTH);
   localparam logic [AW:0]   CNT_ONE = 1;
   localparam logic [AW-1:0] PTR_ONE = 1;

   logic [RW-1:0]      r_mem [DEPTH];
   logic [AW-1:0]      r_wr_ptr;
   logic [AW-1:0]      r_rd_ptr;
   logic [AW:0]        r_count;
   logic [7:0]         r_a;
   logic [18:0]        r_b;
   logic [DBITS-1:0]   r_d;
   logic [5:0]         r_shift;
   logic               r_prop_out;
   logic               r_valid;
   logic               r_prop;
   logic               r_block_start;

   logic               w_push;
   logic               w_pop;
   logic [7:0]         w_head_a;
   logic [18:0]        w_head_b;
   logic [DBITS-1:0]   w_head_d;
   logic [5:0]         w_head_shift;
   logic               w_head_last;

   assign io_in_ready = (r_count < L_DEPTH);
   assign w_push      = io_in_valid & io_in_ready;
   assign w_pop       = ~io_stall & (r_count != '0);
   assign {w_head_a, w_head_b, w_head_d, w_head_shift, w_head_last} = r_mem[r_rd_ptr];

   always_ff @(posedge clock) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= {io_in_a, io_in_b, io_in_d, io_in_shift, io_in_last};
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_ONE;
            2'b01:   r_count <= r_count - CNT_ONE;
            default: r_count <= r_count;
         endcase
      end
   end

   // Shift is latched only on the first row of a block; prop flips once the block's last row leaves.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_a           <= '0;
         r_b           <= '0;
         r_d           <= '0;
         r_shift       <= '0;
         r_prop_out    <= 1'b0;
         r_valid       <= 1'b0;
         r_prop        <= 1'b0;
         r_block_start <= 1'b1;
      end else if (!io_stall) begin
         if (w_pop) begin
            r_valid    <= 1'b1;
            r_a        <= w_head_a;
            r_b        <= w_head_b;
            r_d        <= w_head_d;
            r_prop_out <= r_prop;
            if (r_block_start) r_shift <= w_head_shift;
            if (w_head_last) begin
               r_prop        <= ~r_prop;
               r_block_start <= 1'b1;
            end else begin
               r_block_start <= 1'b0;
            end
         end else begin
            r_valid <= 1'b0;
         end
      end
   end

`ifdef TILE_FEEDER_ZERO_FILL_EN
   assign io_out_a_0 = r_valid ? r_a : '0;
   assign io_out_b_0 = r_valid ? r_b : '0;
   assign io_out_d_0 = r_valid ? r_d : '0;
`else
   assign io_out_a_0 = r_a;
   assign io_out_b_0 = r_b;
   assign io_out_d_0 = r_d;
`endif

   assign io_out_control_0_propagate = r_prop_out;
   assign io_out_control_0_shift     = r_shift;
   assign io_out_valid_0             = r_valid;
   assign io_count                   = r_count;
endmodule

// File: tb/tb_tile_feeder.sv
// Bench for tile_feeder: queue-based reference model checked every cycle, plus directed literal checks.
module tb_tile_feeder;
   localparam int DBITS = 20;
   localparam int DEPTH = 4;

   logic             clock = 1'b0;
   logic             reset;
   logic             io_in_valid;
   logic             io_in_ready;
   logic [7:0]       io_in_a;
   logic [18:0]      io_in_b;
   logic [DBITS-1:0] io_in_d;
   logic [5:0]       io_in_shift;
   logic             io_in_last;
   logic             io_stall;
   logic [7:0]       io_out_a_0;
   logic [18:0]      io_out_b_0;
   logic [DBITS-1:0] io_out_d_0;
   logic             io_out_control_0_propagate;
   logic [5:0]       io_out_control_0_shift;
   logic             io_out_valid_0;
   logic [2:0]       io_count;

   tile_feeder #(.DBITS(DBITS), .DEPTH(DEPTH)) dut (
      .clock(clock), .reset(reset),
      .io_in_valid(io_in_valid), .io_in_ready(io_in_ready),
      .io_in_a(io_in_a), .io_in_b(io_in_b), .io_in_d(io_in_d),
      .io_in_shift(io_in_shift), .io_in_last(io_in_last), .io_stall(io_stall),
      .io_out_a_0(io_out_a_0), .io_out_b_0(io_out_b_0), .io_out_d_0(io_out_d_0),
      .io_out_control_0_propagate(io_out_control_0_propagate),
      .io_out_control_0_shift(io_out_control_0_shift),
      .io_out_valid_0(io_out_valid_0), .io_count(io_count)
   );

   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
      end
   endtask

   typedef struct packed {
      logic [7:0]       a;
      logic [18:0]      b;
      logic [DBITS-1:0] d;
      logic [5:0]       sh;
      logic             last;
   } row_t;

   // Reference model: a queue of rows plus block bookkeeping, advanced once per rising edge.
   row_t             q[$];
   bit               m_started = 0;
   logic             m_valid, m_pr, m_prop, m_bs;
   logic [7:0]       m_a;
   logic [18:0]      m_b;
   logic [DBITS-1:0] m_d;
   logic [5:0]       m_sh;

   always @(posedge clock) begin
      row_t r;
      bit   do_push;
      if (reset) begin
         q.delete();
         m_valid = 0; m_a = 0; m_b = 0; m_d = 0; m_sh = 0; m_pr = 0;
         m_prop = 0; m_bs = 1;
      end else begin
         do_push = io_in_valid && (q.size() < DEPTH);
         if (!io_stall) begin
            if (q.size() > 0) begin
               r = q.pop_front();
               m_valid = 1; m_a = r.a; m_b = r.b; m_d = r.d; m_pr = m_prop;
               if (m_bs) m_sh = r.sh;
               if (r.last) begin m_prop = !m_prop; m_bs = 1; end
               else m_bs = 0;
            end else begin
               m_valid = 0;
            end
         end
         if (do_push) q.push_back({io_in_a, io_in_b, io_in_d, io_in_shift, io_in_last});
      end
      m_started = 1;
   end

   always @(negedge clock) begin
      logic [7:0]       ea;
      logic [18:0]      eb;
      logic [DBITS-1:0] ed;
      if (m_started) begin
`ifdef TILE_FEEDER_ZERO_FILL_EN
         ea = m_valid ? m_a : '0; eb = m_valid ? m_b : '0; ed = m_valid ? m_d : '0;
`else
         ea = m_a; eb = m_b; ed = m_d;
`endif
         chk("valid", 32'(io_out_valid_0), 32'(m_valid));
         chk("out_a", 32'(io_out_a_0), 32'(ea));
         chk("out_b", 32'(io_out_b_0), 32'(eb));
         chk("out_d", 32'(io_out_d_0), 32'(ed));
         chk("propagate", 32'(io_out_control_0_propagate), 32'(m_pr));
         chk("shift", 32'(io_out_control_0_shift), 32'(m_sh));
         chk("count", 32'(io_count), 32'(q.size()));
         chk("in_ready", 32'(io_in_ready), 32'(q.size() < DEPTH));
      end
   end

   task automatic drive(input logic v, input logic [7:0] a, input logic [5:0] sh, input logic last);
      logic [31:0] rb, rd;
      rb = $urandom; rd = $urandom;
      io_in_valid = v; io_in_a = a; io_in_b = rb[18:0]; io_in_d = rd[DBITS-1:0];
      io_in_shift = sh; io_in_last = last;
   endtask

   int vcnt;
   logic [31:0] rnd;

   initial begin
      reset = 1; io_stall = 0;
      drive(0, 8'h00, 6'd0, 0);
      repeat (2) @(negedge clock);
      chk("rst_count", 32'(io_count), 32'd0);
      chk("rst_valid", 32'(io_out_valid_0), 32'd0);
      chk("rst_prop", 32'(io_out_control_0_propagate), 32'd0);
      chk("rst_a", 32'(io_out_a_0), 32'd0);
      reset = 0;
      @(negedge clock);
      chk("rst_ready", 32'(io_in_ready), 32'd1);

      // Three-row block, then a single-row block.
      drive(1, 8'd1, 6'd5, 0);
      @(negedge clock); drive(1, 8'd2, 6'd7, 0);
      @(negedge clock);
      chk("blk_a1", 32'(io_out_a_0), 32'd1);
      chk("blk_v1", 32'(io_out_valid_0), 32'd1);
      chk("blk_p1", 32'(io_out_control_0_propagate), 32'd0);
      chk("blk_s1", 32'(io_out_control_0_shift), 32'd5);
      drive(1, 8'd3, 6'd9, 1);
      @(negedge clock);
      chk("blk_a2", 32'(io_out_a_0), 32'd2);
      chk("blk_s2", 32'(io_out_control_0_shift), 32'd5);
      chk("blk_p2", 32'(io_out_control_0_propagate), 32'd0);
      drive(0, 8'd0, 6'd0, 0);
      @(negedge clock);
      chk("blk_a3", 32'(io_out_a_0), 32'd3);
      chk("blk_s3", 32'(io_out_control_0_shift), 32'd5);
      chk("blk_p3", 32'(io_out_control_0_propagate), 32'd0);
      drive(1, 8'd4, 6'd11, 1);
      @(negedge clock);
      chk("blk_idle_v", 32'(io_out_valid_0), 32'd0);
      drive(0, 8'd0, 6'd0, 0);
      @(negedge clock);
      chk("blk_a4", 32'(io_out_a_0), 32'd4);
      chk("blk_p4", 32'(io_out_control_0_propagate), 32'd1);
      chk("blk_s4", 32'(io_out_control_0_shift), 32'd11);
      repeat (2) @(negedge clock);

      // Fill under stall: six offered, four accepted, four drained.
      io_stall = 1;
      for (int i = 0; i < 6; i++) begin
         if (i == 4) begin
            chk("full_count", 32'(io_count), 32'd4);
            chk("full_ready", 32'(io_in_ready), 32'd0);
         end
         drive(1, 8'(8'h20 + i), 6'(i), 0);
         @(negedge clock);
      end
      drive(0, 8'd0, 6'd0, 0);
      io_stall = 0;
      vcnt = 0;
      repeat (6) begin
         @(negedge clock);
         if (io_out_valid_0) vcnt++;
      end
      chk("drain_cycles", 32'(vcnt), 32'd4);
      repeat (2) @(negedge clock);

      // Two-cycle stall in the middle of a stream.
      vcnt = 0;
      for (int i = 0; i < 14; i++) begin
         @(negedge clock);
         if (i >= 3 && i <= 5) chk("stall_frozen_a", 32'(io_out_a_0), 32'h11);
         if (i == 6) chk("stall_resume_a", 32'(io_out_a_0), 32'h12);
         if (io_out_valid_0) vcnt++;
         if (i < 8) drive(1, 8'(8'h10 + i), 6'(i), (i == 7));
         else drive(0, 8'd0, 6'd0, 0);
         io_stall = (i == 3 || i == 4);
      end
      chk("stall_valid_cycles", 32'(vcnt), 32'd10);

      // Reset with three queued rows.
      io_stall = 1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clock); drive(1, 8'(8'h30 + i), 6'd2, 0);
      end
      @(negedge clock);
      drive(0, 8'd0, 6'd0, 0);
      io_stall = 0; reset = 1;
      @(negedge clock);
      reset = 0;
      chk("mrst_count", 32'(io_count), 32'd0);
      chk("mrst_valid", 32'(io_out_valid_0), 32'd0);
      chk("mrst_prop", 32'(io_out_control_0_propagate), 32'd0);
      chk("mrst_ready", 32'(io_in_ready), 32'd1);
      drive(1, 8'h77, 6'd13, 0);
      @(negedge clock); drive(0, 8'd0, 6'd0, 0);
      @(negedge clock);
      chk("mrst_a", 32'(io_out_a_0), 32'h77);
      chk("mrst_p", 32'(io_out_control_0_propagate), 32'd0);
      chk("mrst_s", 32'(io_out_control_0_shift), 32'd13);

      // Idle data behaviour after the FIFO empties.
      drive(1, 8'h5A, 6'd1, 1);
      @(negedge clock); drive(0, 8'd0, 6'd0, 0);
      @(negedge clock);
      chk("idle_a_live", 32'(io_out_a_0), 32'h5A);
      @(negedge clock);
      chk("idle_valid", 32'(io_out_valid_0), 32'd0);
`ifdef TILE_FEEDER_ZERO_FILL_EN
      chk("idle_a", 32'(io_out_a_0), 32'h00);
`else
      chk("idle_a", 32'(io_out_a_0), 32'h5A);
`endif

      // Random traffic with stalls and occasional resets.
      repeat (3000) begin
         @(negedge clock);
         rnd = $urandom;
         reset    = (rnd[9:0] < 10'd4);
         io_stall = (rnd[12:11] == 2'b00);
         drive(rnd[15:14] != 2'b00, rnd[23:16], rnd[29:24], rnd[31:30] == 2'b00);
      end
      @(negedge clock);
      reset = 0; io_stall = 0;
      drive(0, 8'd0, 6'd0, 0);
      repeat (8) @(negedge clock);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
